// File: rtl/x_input_buffer.sv
// x_input_buffer: FIFO front-end for the series-evaluation controller.
// Buffers producer x samples and their last flags. Each frame is announced
// with a one-cycle start pulse, and the samples are then presented under
// in_valid/ready handshaking. A frame longer than MAX_FRAME sets a sticky
// error.
// Optional feature: define XBUF_PEAK_EN to add the 'peak' occupancy output.
module x_input_buffer #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int MAX_FRAME = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   start,
  output logic                   in_valid,
  output logic [WIDTH-1:0]       x_data,
  output logic                   x_last,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   error
`ifdef XBUF_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0] peak
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = (MAX_FRAME > 1) ? $clog2(MAX_FRAME) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SOF    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Storage: each entry is {last, data}
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [FCW-1:0]  fc_q, fc_d;
  logic            error_q, error_d;
  logic            start_q, start_d;
  logic            in_valid_q, in_valid_d;
  logic            push_s, pop_s;
  logic            head_last_s;

  assign s_ready     = (count_q != CW'(DEPTH));
  assign head_last_s = mem_q[rd_ptr_q][WIDTH];
  assign start       = start_q;
  assign in_valid    = in_valid_q;
  assign x_data      = mem_q[rd_ptr_q][WIDTH-1:0];
  assign x_last      = head_last_s;
  assign count       = count_q;
  assign error       = error_q;

  // Next-state logic for pointers, occupancy, framing FSM and error flag
  always_comb begin
    push_s   = s_valid && s_ready;
    pop_s    = in_valid_q && ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    fc_d     = fc_q;
    error_d  = error_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          state_d = ST_SOF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SOF: begin
        state_d = ST_STREAM;
        fc_d    = {FCW{1'b0}};
      end
      ST_STREAM: begin
        if (pop_s) begin
          if (head_last_s) begin
            state_d = ST_IDLE;
          end else if (fc_q == FCW'(MAX_FRAME - 1)) begin
            // Over-long frame: flag it and treat this sample as the last one
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fc_d = fc_q + FCW'(1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d    = (state_d == ST_SOF);
    in_valid_d = (state_d == ST_STREAM) && (count_d != {CW{1'b0}});
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      state_q    <= ST_IDLE;
      fc_q       <= {FCW{1'b0}};
      error_q    <= 1'b0;
      start_q    <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      fc_q       <= fc_d;
      error_q    <= error_d;
      start_q    <= start_d;
      in_valid_q <= in_valid_d;
    end
  end

  // Sample storage write port; contents need no reset because the pointers gate validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

`ifdef XBUF_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  assign peak = peak_q;

  // Track the highest registered occupancy seen since reset
  always_comb begin
    if (count_q > peak_q) begin
      peak_d = count_q;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= {CW{1'b0}};
    end else begin
      peak_q <= peak_d;
    end
  end
`endif

endmodule
